// File: rtl/regbank_array.sv
// ---------------------------------------------------------------------------
// regbank_array
//   Register storage for the REGBANK in the ID stage. It holds 2^SELECT_BITS
//   words of DATA_BITS.
//   - Writes arrive on a one-hot enable vector from the write-select demux.
//   - Two combinational read ports serve the decode stage. Each has a
//     same-cycle write-through bypass.
//   - A valid/ready dump port lets the debug unit stream out every register
//     in index order.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   wr_en[N-1:0]              one-hot write enable; bit i writes register i
//                             (bit 0 ignored)
//   wr_data                   write data
//   rd_addr_a/b, rd_data_a/b  independent combinational read ports
//   onehot_err                sticky: wr_en ever had more than one bit set
//   dump_start                request a full dump (only looked at while idle)
//   dump_valid/dump_ready     dump handshake
//   dump_data/dump_index      word being presented and its register index
//   dump_done                 one-cycle pulse after the last word is accepted
//   busy                      dump engine not idle
//
// Dump handshake: a word transfers on any rising edge where dump_valid and
// dump_ready are both high. While dump_valid is high and dump_ready is low,
// dump_index and dump_data stay stable, unless the presented register itself
// is written. Once dump_valid rises, it stays high until the word transfers.
// ---------------------------------------------------------------------------
module regbank_array #(
  parameter int SELECT_BITS = 5,
  parameter int DATA_BITS   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(1<<SELECT_BITS)-1:0] wr_en,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic [SELECT_BITS-1:0]      rd_addr_a,
  input  logic [SELECT_BITS-1:0]      rd_addr_b,
  output logic [DATA_BITS-1:0]        rd_data_a,
  output logic [DATA_BITS-1:0]        rd_data_b,
  output logic                        onehot_err,
  input  logic                        dump_start,
  output logic                        dump_valid,
  input  logic                        dump_ready,
  output logic [DATA_BITS-1:0]        dump_data,
  output logic [SELECT_BITS-1:0]      dump_index,
  output logic                        dump_done,
  output logic                        busy
);

  localparam int N = 1 << SELECT_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_mem [N];

  // Word 0 is cleared on reset and never loaded, so it always reads zero.
  // The read paths also force zero for address 0, so this is not relied on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < N; i++) begin
        if (wr_en[i]) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // One-hot checker
  // -------------------------------------------------------------------------
  // x & (x-1) clears the lowest set bit. Any remaining bit means two or more
  // enables were set. Bit 0 still counts towards the popcount.
  logic [N-1:0] w_wr_en_minus1;
  logic         w_multi_hot;
  logic         r_onehot_err;

  assign w_wr_en_minus1 = wr_en - {{(N-1){1'b0}}, 1'b1};
  assign w_multi_hot    = |(wr_en & w_wr_en_minus1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_onehot_err <= 1'b0;
    end else if (w_multi_hot) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign onehot_err = r_onehot_err;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  // The bypass forwards wr_data when the addressed register is being written
  // this cycle. This lets a writeback and a decode read of the same register
  // share a cycle without a stall.
  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != '0) begin
      if (wr_en[rd_addr_a]) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = r_mem[rd_addr_a];
      end
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != '0) begin
      if (wr_en[rd_addr_b]) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = r_mem[rd_addr_b];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Dump engine
  // -------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SELECT_BITS-1:0] r_dump_idx;
  logic [SELECT_BITS-1:0] w_dump_idx_nxt;
  logic                   w_handshake;
  logic                   w_last_idx;

  // Internal view of the dump state, for checkers bound to this module.
  logic [1:0]             w_dbg_state;
  assign w_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dump_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dump_idx <= w_dump_idx_nxt;
    end
  end

  assign w_last_idx  = &r_dump_idx;
  assign w_handshake = dump_valid & dump_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_dump_idx_nxt = r_dump_idx;
    dump_valid     = 1'b0;
    dump_done      = 1'b0;
    busy           = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (dump_start) begin
          w_state_nxt    = ST_SEND;
          w_dump_idx_nxt = '0;
        end
      end
      ST_SEND: begin
        dump_valid = 1'b1;
        if (w_handshake) begin
          if (w_last_idx) begin
            // The index returns to 0 rather than wrapping while still in SEND.
            w_state_nxt    = ST_DONE;
            w_dump_idx_nxt = '0;
          end else begin
            w_dump_idx_nxt = r_dump_idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // dump_start is not looked at here. A request held high across DONE
        // starts a new dump only after one cycle back in IDLE.
        dump_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_dump_idx_nxt = '0;
      end
    endcase
  end

  // The dump reads stored contents only. A write that lands on the same edge
  // as a word's handshake does not change that word.
  always_comb begin
    dump_data = '0;
    if (r_dump_idx != '0) begin
      dump_data = r_mem[r_dump_idx];
    end
  end

  assign dump_index = r_dump_idx;

endmodule

// File: tb/tb_regbank_array.sv
module tb_regbank_array;

  localparam int SB = 5;
  localparam int DB = 32;
  localparam int N  = 1 << SB;

  logic          clk;
  logic          rst;
  logic [N-1:0]  wr_en;
  logic [DB-1:0] wr_data;
  logic [SB-1:0] rd_addr_a;
  logic [SB-1:0] rd_addr_b;
  logic [DB-1:0] rd_data_a;
  logic [DB-1:0] rd_data_b;
  logic          onehot_err;
  logic          dump_start;
  logic          dump_valid;
  logic          dump_ready;
  logic [DB-1:0] dump_data;
  logic [SB-1:0] dump_index;
  logic          dump_done;
  logic          busy;

  int n_checks;
  int n_fail;

  // Reference register contents, maintained by the bench as it writes.
  logic [DB-1:0] mdl [N];

  regbank_array #(.SELECT_BITS(SB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .onehot_err (onehot_err),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_index (dump_index),
    .dump_done  (dump_done),
    .busy       (busy)
  );

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Driver helpers
  // -------------------------------------------------------------------------
  // Advance one clock. Return just after the edge, so inputs change away
  // from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int            idx;
    logic [DB-1:0] prev_data;
    logic [SB-1:0] prev_idx;

    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    wr_en      = '0;
    wr_data    = '0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = '0;

    tick();
    tick();
    rst = 1'b0;
    #1;

    // 1. Reset state: every address reads zero on both ports.
    for (int a = 0; a < N; a++) begin
      rd_addr_a = SB'(a);
      rd_addr_b = SB'(N - 1 - a);
      #1;
      chk($sformatf("rst_rd_a[%0d]", a), rd_data_a, '0);
      chk($sformatf("rst_rd_b[%0d]", N - 1 - a), rd_data_b, '0);
    end
    chk("rst_onehot_err", DB'(onehot_err), '0);
    chk("rst_busy",       DB'(busy),       '0);
    chk("rst_dump_valid", DB'(dump_valid), '0);
    chk("rst_dump_done",  DB'(dump_done),  '0);
    chk("rst_dump_index", DB'(dump_index), '0);

    // 2. Write reg 5. It bypasses in the same cycle and is stored after the edge.
    tick();
    wr_en     = N'(1) << 5;
    wr_data   = 32'hDEADBEEF;
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd5;
    #1;
    chk("bypass_a_r5", rd_data_a, 32'hDEADBEEF);
    chk("bypass_b_r5", rd_data_b, 32'hDEADBEEF);
    tick();
    mdl[5] = 32'hDEADBEEF;
    wr_en  = '0;
    #1;
    chk("stored_a_r5", rd_data_a, 32'hDEADBEEF);

    // 3. A write to reg 0 is ignored, does not bypass, and is not an error.
    wr_en     = N'(1);
    wr_data   = 32'hFFFFFFFF;
    rd_addr_b = 5'd0;
    #1;
    chk("r0_bypass_b", rd_data_b, '0);
    tick();
    wr_en = '0;
    #1;
    chk("r0_stored_b",     rd_data_b,        '0);
    chk("r0_no_onehot_err", DB'(onehot_err), '0);

    // 4. A double-hot write sets the sticky error and still writes both registers.
    wr_en   = (N'(1) << 3) | (N'(1) << 7);
    wr_data = 32'h12;
    #1;
    chk("multi_err_before_edge", DB'(onehot_err), '0);
    tick();
    mdl[3]    = 32'h12;
    mdl[7]    = 32'h12;
    wr_en     = '0;
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd7;
    #1;
    chk("multi_r3",  rd_data_a,        32'h12);
    chk("multi_r7",  rd_data_b,        32'h12);
    chk("multi_err", DB'(onehot_err),  32'h1);
    rd_addr_a = 5'd5;
    #1;
    chk("r5_untouched", rd_data_a, 32'hDEADBEEF);
    tick();
    tick();
    chk("multi_err_sticky", DB'(onehot_err), 32'h1);

    // 5. Load reg i = i*4+1, then dump with dump_ready held high.
    for (int i = 1; i < N; i++) begin
      wr_en   = N'(1) << i;
      wr_data = DB'(i * 4 + 1);
      tick();
      mdl[i] = DB'(i * 4 + 1);
    end
    wr_en      = '0;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    #1;
    chk("pre_dump_busy", DB'(busy), '0);
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < N; k++) begin
      wr_en = '0;
      // Writing the presented register on its handshake edge must not change
      // the word. A register written before it is presented must show the
      // new value.
      if (k == 2) begin
        wr_en   = N'(1) << 2;
        wr_data = 32'h0000AAAA;
      end
      if (k == 4) begin
        wr_en   = N'(1) << 5;
        wr_data = 32'h0000BBBB;
      end
      #1;
      chk($sformatf("dump_valid[%0d]", k), DB'(dump_valid), 32'h1);
      chk($sformatf("dump_index[%0d]", k), DB'(dump_index), DB'(k));
      chk($sformatf("dump_data[%0d]", k),  dump_data,       mdl[k]);
      chk($sformatf("dump_done_early[%0d]", k), DB'(dump_done), '0);
      tick();
      if (k == 2) mdl[2] = 32'h0000AAAA;
      if (k == 4) mdl[5] = 32'h0000BBBB;
    end
    wr_en = '0;
    // Cycle 33 after the start edge: the done pulse.
    chk("dump_done_pulse",  DB'(dump_done),  32'h1);
    chk("dump_done_valid",  DB'(dump_valid), '0);
    chk("dump_done_busy",   DB'(busy),       32'h1);
    chk("dump_done_index",  DB'(dump_index), '0);
    tick();
    chk("post_dump_done", DB'(dump_done), '0);
    chk("post_dump_busy", DB'(busy),      '0);
    rd_addr_a = 5'd2;
    rd_addr_b = 5'd5;
    #1;
    chk("dump_wr_r2", rd_data_a, 32'h0000AAAA);
    chk("dump_wr_r5", rd_data_b, 32'h0000BBBB);

    // 6. Dump with dump_ready toggling, aborted by reset at index 10.
    dump_start = 1'b1;
    dump_ready = 1'b0;
    tick();
    dump_start = 1'b0;
    idx        = 0;
    prev_data  = '0;
    prev_idx   = '0;
    for (int c = 0; c < 4 * N; c++) begin
      if (idx == 10) break;
      dump_ready = (c % 2 == 0);
      #1;
      chk($sformatf("stall_index[c%0d]", c), DB'(dump_index), DB'(idx));
      chk($sformatf("stall_data[c%0d]", c),  dump_data,       mdl[idx]);
      if (c > 0 && prev_idx == SB'(idx)) begin
        chk($sformatf("stall_hold[c%0d]", c), dump_data, prev_data);
      end
      prev_data = dump_data;
      prev_idx  = dump_index;
      if (dump_ready) idx++;
      tick();
    end
    chk("abort_reached_idx10", DB'(dump_index), 32'd10);
    dump_ready = 1'b1;
    rst        = 1'b1;
    #1;
    chk("abort_busy",       DB'(busy),       '0);
    chk("abort_dump_valid", DB'(dump_valid), '0);
    chk("abort_dump_index", DB'(dump_index), '0);
    chk("abort_dump_done",  DB'(dump_done),  '0);
    chk("abort_onehot_err", DB'(onehot_err), '0);
    for (int i = 0; i < N; i++) mdl[i] = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("abort_no_done[%0d]", c), DB'(dump_done), '0);
      chk($sformatf("abort_idle[%0d]", c),    DB'(busy),      '0);
      tick();
    end
    for (int a = 0; a < N; a++) begin
      rd_addr_a = SB'(a);
      rd_addr_b = SB'(a);
      #1;
      chk($sformatf("abort_rd_a[%0d]", a), rd_data_a, mdl[a]);
      chk($sformatf("abort_rd_b[%0d]", a), rd_data_b, mdl[a]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound, in case anything above stops advancing.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
